// File: rtl/shift_deser_pkg.sv
// shift_deser_pkg: shared state encoding and beat-count helper for the shift deserializer.
package shift_deser_pkg;
    typedef enum logic [0:0] {OUT_EMPTY, OUT_FULL} out_state_e;

    function automatic int beats(input int from, input int to);
        return from / to;
    endfunction
endpackage

// File: rtl/deser_out_stage.sv
// deser_out_stage: one-word output register with valid/ready handshake.
// Holds a completed word until consumed; a load in the consume cycle refills it without a bubble.
module deser_out_stage
    import shift_deser_pkg::*;
#(
    parameter int FROM = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic [FROM-1:0] word,
    input  logic            ready_i,
    output logic [FROM-1:0] data_o,
    output logic            valid_o
);
    out_state_e state_q, state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= OUT_EMPTY;
            data_o  <= '0;
        end else begin
            state_q <= state_d;
            if (load) data_o <= word;
        end
    end

    always_comb begin
        state_d = (load || (state_q == OUT_FULL && !ready_i)) ? OUT_FULL : OUT_EMPTY;
    end

    assign valid_o = state_q == OUT_FULL;
endmodule

// File: rtl/shift_deserializer.sv
// shift_deserializer: gathers FROM/TO beats of TO bits (first beat = MS chunk) into one FROM-bit word.
// Optional SHIFT_DESER_FLUSH_EN adds flush_i to discard a partially gathered word.
`ifndef SHIFT_FROM
`define SHIFT_FROM 32
`endif
`ifndef SHIFT_TO
`define SHIFT_TO 4
`endif
`ifndef SHIFT_LOGBEATS
`define SHIFT_LOGBEATS 3
`endif

module shift_deserializer
    import shift_deser_pkg::*;
#(
    parameter int FROM      = `SHIFT_FROM,
    parameter int TO        = `SHIFT_TO,
    parameter int LOG2BEATS = `SHIFT_LOGBEATS
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [TO-1:0]   data_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic [FROM-1:0] data_o,
    output logic            valid_o,
    input  logic            ready_i
`ifdef SHIFT_DESER_FLUSH_EN
    ,
    input  logic            flush_i
`endif
);
    localparam int BEATS = beats(FROM, TO);
    localparam logic [LOG2BEATS-1:0] LAST = LOG2BEATS'(BEATS - 1);

    logic [FROM-1:0]      acc, shifted;
    logic [LOG2BEATS-1:0] cnt;
    logic                 flush, last, accept, load;

`ifdef SHIFT_DESER_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    assign last    = cnt == LAST;
    assign shifted = {acc[FROM-TO-1:0], data_i};
    // Only the final beat must wait for a full, unconsumed output register.
    assign ready_o = flush || !(last && valid_o && !ready_i);
    assign accept  = valid_i && ready_o;
    assign load    = accept && last && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (flush) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= shifted;
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    deser_out_stage #(.FROM(FROM)) u_out (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .word    (shifted),
        .ready_i (ready_i),
        .data_o  (data_o),
        .valid_o (valid_o)
    );
endmodule

// File: tb/tb_shift_deserializer.sv
// tb_shift_deserializer: directed bench for the 8-bit/2-bit deserializer with a word scoreboard.
// Flush scenario is included when SHIFT_DESER_FLUSH_EN is defined.
module tb_shift_deserializer;
    logic       clk = 0;
    logic       reset_n = 0;
    logic [1:0] data_i = '0;
    logic       valid_i = 0;
    logic       ready_o;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i = 1;
`ifdef SHIFT_DESER_FLUSH_EN
    logic       flush_i = 0;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] q[$];
    logic [7:0] m_acc = '0;
    int m_cnt = 0;
    int w;

    shift_deserializer #(.FROM(8), .TO(2), .LOG2BEATS(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
`ifdef SHIFT_DESER_FLUSH_EN
        ,
        .flush_i (flush_i)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one beat and hold it until accepted; the model pushes each completed word.
    task automatic send(input logic [1:0] d, output int waits);
        data_i  = d;
        valid_i = 1;
        waits   = 0;
        @(negedge clk);
        while (!ready_o && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!ready_o) check("send_timeout", waits, 0);
        else begin
            if (m_cnt == 3) begin
                q.push_back({m_acc[5:0], d});
                m_cnt = 0;
            end else m_cnt++;
            m_acc = {m_acc[5:0], d};
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset_n && valid_o && ready_i) begin
            if (q.size() == 0) check("unexpected_word", data_o, 0);
            else check("word", data_o, q.pop_front());
        end
    end

    logic [1:0] b2b [8] = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_ready", ready_o, 1);
        reset_n = 1;

        // 1: single word C9, valid for exactly one cycle
        send(2'b11, w); send(2'b00, w); send(2'b10, w); send(2'b01, w);
        valid_i = 0;
        @(negedge clk);
        check("t1_valid", valid_o, 1);
        check("t1_data", data_o, 8'hC9);
        @(negedge clk);
        check("t1_valid_drop", valid_o, 0);
        @(posedge clk); #1;

        // 2: back-to-back C9, 5A, never stalled
        for (int i = 0; i < 8; i++) begin
            send(b2b[i], w);
            check("t2_no_stall", w, 0);
        end
        valid_i = 0;
        @(negedge clk);
        check("t2_data", data_o, 8'h5A);
        @(posedge clk); #1;

        // 3: output full, next word's last beat stalls until ready_i
        ready_i = 0;
        send(2'b00, w); send(2'b01, w); send(2'b00, w); send(2'b10, w);
        send(2'b10, w); check("t3_b0", w, 0);
        send(2'b01, w); check("t3_b1", w, 0);
        send(2'b11, w); check("t3_b2", w, 0);
        data_i = 2'b11;
        valid_i = 1;
        @(negedge clk);
        check("t3_stall_ready", ready_o, 0);
        check("t3_hold_data", data_o, 8'h12);
        check("t3_hold_valid", valid_o, 1);
        @(posedge clk); #1;
        ready_i = 1;
        send(2'b11, w);
        check("t3_accept", w, 0);
        valid_i = 0;
        @(negedge clk);
        check("t3_no_bubble", valid_o, 1);
        check("t3_word2", data_o, 8'h9F);
        repeat (2) @(posedge clk);
        #1;

        // 4: gap after beat 1 freezes the counter
        send(2'b11, w); send(2'b10, w);
        valid_i = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_cnt", dut.cnt, 2);
            check("t4_valid", valid_o, 0);
        end
        @(posedge clk); #1;
        send(2'b01, w); send(2'b00, w);
        valid_i = 0;
        @(negedge clk);
        check("t4_data", data_o, 8'hE4);
        @(posedge clk); #1;

        // 5: async reset with a held word and a partial word
        ready_i = 0;
        send(2'b00, w); send(2'b11, w); send(2'b00, w); send(2'b11, w);
        send(2'b10, w); send(2'b10, w);
        valid_i = 0;
        check("t5_pre_valid", valid_o, 1);
        reset_n = 0;
        #1;
        check("t5_valid", valid_o, 0);
        check("t5_data", data_o, 0);
        check("t5_ready", ready_o, 1);
        check("t5_cnt", dut.cnt, 0);
        q.delete();
        m_cnt = 0;
        m_acc = '0;
        @(posedge clk); #1;
        reset_n = 1;
        ready_i = 1;
        repeat (4) send(2'b01, w);
        valid_i = 0;
        @(negedge clk);
        check("t5_data55", data_o, 8'h55);
        @(posedge clk); #1;

`ifdef SHIFT_DESER_FLUSH_EN
        // 6: flush discards the partial word and the same-cycle beat
        send(2'b00, w); send(2'b11, w);
        data_i  = 2'b01;
        valid_i = 1;
        flush_i = 1;
        @(negedge clk);
        check("t6_flush_ready", ready_o, 1);
        @(posedge clk); #1;
        flush_i = 0;
        m_cnt = 0;
        m_acc = '0;
        repeat (4) send(2'b10, w);
        valid_i = 0;
        @(negedge clk);
        check("t6_data", data_o, 8'hAA);
        @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        #1;
        check("drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
